// File: rtl/spi_bus_arbiter_if.sv
// Requester handshake and SPI pin bundle for spi_bus_arbiter.
// master: the arbiter side; slave: requesters plus SPI pins as seen from the board.
interface spi_bus_arbiter_if #(
   parameter int NumReq    = 2,
   parameter int DataWidth = 8
);
   logic [NumReq-1:0]           req_valid;
   logic [NumReq*DataWidth-1:0] req_data;
   logic [NumReq-1:0]           req_last;
   logic [NumReq-1:0]           req_ready;
   logic [NumReq-1:0]           rsp_valid;
   logic [DataWidth-1:0]        rsp_data;
   logic [NumReq-1:0]           grant;
   logic                        timeout;
   logic                        spi_sck;
   logic                        spi_tx;
   logic                        spi_rx;
   logic [NumReq-1:0]           spi_cs_n;

   modport master (
      input  req_valid, req_data, req_last, spi_rx,
      output req_ready, rsp_valid, rsp_data, grant, timeout, spi_sck, spi_tx, spi_cs_n
   );

   modport slave (
      output req_valid, req_data, req_last, spi_rx,
      input  req_ready, rsp_valid, rsp_data, grant, timeout, spi_sck, spi_tx, spi_cs_n
   );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin SPI bus arbiter with mode-0 MSB-first shift engine and per-requester chip selects.
// Optional WAIT timeout release is enabled by defining SPI_ARB_TIMEOUT_EN.
//
//  state    | meaning
//  ST_IDLE  | no owner, cs all high, pick round-robin winner
//  ST_SHIFT | shifting one word for the owner, cs low
//  ST_WAIT  | between words of a burst, cs low, sck low
//  ST_GAP   | cs all high for ClkDiv cycles before IDLE
module spi_bus_arbiter #(
   parameter int NumReq        = 2,
   parameter int DataWidth     = 8,
   parameter int ClkDiv        = 2,
   parameter int TimeoutCycles = 256
) (
   input  logic              clk_sys,
   input  logic              rst_sys,
   spi_bus_arbiter_if.master bus
);
   localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
   localparam int BitW = $clog2(DataWidth + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT, ST_GAP} state_t;

   state_t                state_q, state_d;
   logic [PtrW-1:0]       owner_q, rr_ptr_q;
   logic                  last_q;
   logic [DataWidth-1:0]  tx_sr_q, rx_sr_q;
   logic [DivW-1:0]       div_cnt_q;
   logic                  phase_q;
   logic [BitW-1:0]       bit_cnt_q;

   logic                  win_found;
   logic [PtrW-1:0]       win_idx;
   logic                  accept;
   logic [PtrW-1:0]       accept_idx;
   logic [NumReq-1:0]     owner_oh;
   logic                  byte_done, div_end, timeout_hit;
   logic [NumReq-1:0]     ready, rsp_valid, grant, cs_n;
   logic                  sck, tx, timeout;

   assign owner_oh  = NumReq'(1) << owner_q;
   assign byte_done = (state_q == ST_SHIFT) && (bit_cnt_q == BitW'(DataWidth));
   assign div_end   = (div_cnt_q == DivW'(ClkDiv - 1));

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int WaitW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   logic [WaitW-1:0] wait_cnt_q;

   assign timeout_hit = (wait_cnt_q == WaitW'(TimeoutCycles - 1));

   always_ff @(posedge clk_sys) begin
      if (rst_sys || state_q != ST_WAIT) begin
         wait_cnt_q <= '0;
      end else if (!bus.req_valid[owner_q]) begin
         wait_cnt_q <= wait_cnt_q + WaitW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
   if (TimeoutCycles < 1) begin : g_bad_timeout_cfg
   end
`endif

   // search starts just after the last owner so every requester gets a turn
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 1; i <= NumReq; i++) begin
         if (!win_found && bus.req_valid[(int'(rr_ptr_q) + i) % NumReq]) begin
            win_found = 1'b1;
            win_idx   = PtrW'((int'(rr_ptr_q) + i) % NumReq);
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst_sys) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      accept_idx = owner_q;
      ready      = '0;
      rsp_valid  = '0;
      grant      = '0;
      cs_n       = '1;
      sck        = 1'b0;
      tx         = 1'b0;
      timeout    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               accept     = 1'b1;
               accept_idx = win_idx;
               ready      = NumReq'(1) << win_idx;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            grant = owner_oh;
            cs_n  = ~owner_oh;
            sck   = phase_q;
            tx    = tx_sr_q[DataWidth-1];
            if (byte_done) begin
               rsp_valid = owner_oh;
               state_d   = last_q ? ST_GAP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            grant = owner_oh;
            cs_n  = ~owner_oh;
            if (bus.req_valid[owner_q]) begin
               accept  = 1'b1;
               ready   = owner_oh;
               state_d = ST_SHIFT;
            end else if (timeout_hit) begin
               timeout = 1'b1;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (div_end) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // the FSM may still sit in IDLE/SHIFT during the reset cycle; keep handshakes quiet
      if (rst_sys) begin
         accept    = 1'b0;
         ready     = '0;
         rsp_valid = '0;
         timeout   = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         owner_q   <= '0;
         rr_ptr_q  <= PtrW'(NumReq - 1);
         last_q    <= 1'b0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         div_cnt_q <= '0;
         phase_q   <= 1'b0;
         bit_cnt_q <= '0;
      end else if (accept) begin
         owner_q   <= accept_idx;
         rr_ptr_q  <= accept_idx;
         last_q    <= bus.req_last[accept_idx];
         tx_sr_q   <= bus.req_data[int'(accept_idx)*DataWidth +: DataWidth];
         div_cnt_q <= '0;
         phase_q   <= 1'b0;
         bit_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_SHIFT: begin
               if (byte_done) begin
                  div_cnt_q <= '0;
               end else if (div_end) begin
                  div_cnt_q <= '0;
                  phase_q   <= ~phase_q;
                  if (!phase_q) begin
                     rx_sr_q <= {rx_sr_q[DataWidth-2:0], bus.spi_rx};
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BitW'(1);
                     tx_sr_q   <= {tx_sr_q[DataWidth-2:0], 1'b0};
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + DivW'(1);
               end
            end
            ST_WAIT: div_cnt_q <= '0;
            ST_GAP:  div_cnt_q <= div_cnt_q + DivW'(1);
            default: begin
            end
         endcase
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rx_sr_q;
   assign bus.grant     = grant;
   assign bus.timeout   = timeout;
   assign bus.spi_sck   = sck;
   assign bus.spi_tx    = tx;
   assign bus.spi_cs_n  = cs_n;
endmodule
